// File: rtl/rx_dsp_ctrl_pkg.sv
// Shared definitions for the RX DSP configuration sequencer.
//   state_e         : sequencer FSM states
//   DEF_*_CYCLES    : default drain / reset / settle durations
//   CFG_WORD_WIDTH  : config word width, shared with the FIR array
//   max3()          : helper used to size the shared cycle counter
package rx_dsp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RST,
    ST_LOAD,
    ST_SETTLE,
    ST_ABRST
  } state_e;

  localparam int unsigned DEF_DRAIN_CYCLES  = 16;
  localparam int unsigned DEF_RST_CYCLES    = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 32;
  localparam int unsigned CFG_WORD_WIDTH    = 32;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rx_cfg_ram.sv
// Config word RAM: simple dual-port synchronous RAM, one write port and one
// read port, read latency 1. The array is not reset; the read register is,
// so the word it presents is 0 out of reset. The read register only updates
// when re is high, so its output holds the last word read.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   we, waddr, wdata    write port
//   re, raddr, rdata    read port (rdata valid the cycle after re)
module rx_cfg_ram
  import rx_dsp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = CFG_WORD_WIDTH,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rx_dsp_cfg_sequencer.sv
// RX FIR decimation chain reconfiguration sequencer (DSP clock domain).
// On start: holds the datapath (dp_hold) for DRAIN_CYCLES, pulses cfg_rst for
// RST_CYCLES, streams min(count, 2**DEPTH_BITS) preloaded RAM words on
// cfg_valid/cfg_data, waits SETTLE_CYCLES, then pulses done and releases.
// abort while busy forces a RST_CYCLES cfg_rst, then pulses aborted.
// Ports:
//   clk, rst_n                  DSP clock, async active-low reset
//   wr_en, wr_addr, wr_data     host RAM write (dropped while busy)
//   wr_rej                      pulse: previous-cycle write was dropped
//   start, count, abort         sequence control
//   busy, done, aborted         status
//   dp_hold, cfg_rst            datapath hold, FIR config reset
//   cfg_valid, cfg_data         config word stream
//   cfg_chksum                  sum of words of last LOAD (RX_CFG_CHKSUM_EN only)
// Optional feature macro: RX_CFG_CHKSUM_EN
module rx_dsp_cfg_sequencer
  import rx_dsp_ctrl_pkg::*;
#(
  parameter int unsigned CFG_WIDTH     = CFG_WORD_WIDTH,
  parameter int unsigned DEPTH_BITS    = 6,
  parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [CFG_WIDTH-1:0]  wr_data,
  output logic                  wr_rej,
  input  logic                  start,
  input  logic [DEPTH_BITS:0]   count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  dp_hold,
  output logic                  cfg_rst,
  output logic                  cfg_valid,
`ifdef RX_CFG_CHKSUM_EN
  output logic [CFG_WIDTH-1:0]  cfg_chksum,
`endif
  output logic [CFG_WIDTH-1:0]  cfg_data
);

  if (DRAIN_CYCLES == 0 || RST_CYCLES == 0 || SETTLE_CYCLES == 0) begin : g_bad_params
    $error("rx_dsp_cfg_sequencer: DRAIN/RST/SETTLE cycle parameters must be non-zero");
  end

  localparam int unsigned CW = $clog2(max3(DRAIN_CYCLES, RST_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [DEPTH_BITS:0] MAX_WORDS = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] WORD_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic SETTLE_IS_ONE = (SETTLE_CYCLES == 1);

  state_e                state_q;
  logic [CW-1:0]         cyc_q;
  logic [DEPTH_BITS:0]   cnt_q;
  logic [DEPTH_BITS:0]   rd_cnt_q;
  logic                  busy_q, done_q, aborted_q, dp_hold_q;
  logic                  cfg_rst_q, cfg_valid_q, wr_rej_q;
  logic                  rd_en;
  logic                  ram_we;
  logic [CFG_WIDTH-1:0]  rdata;
`ifdef RX_CFG_CHKSUM_EN
  logic [CFG_WIDTH-1:0]  chksum_q;
`endif

  assign ram_we = wr_en && !busy_q;

  // Reads are issued one cycle ahead of cfg_valid: the first in the last RST
  // cycle, then back to back in LOAD until cnt_q words have been read.
  always_comb begin
    rd_en = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_RST:  rd_en = (cyc_q == '0) && (cnt_q != '0);
        ST_LOAD: rd_en = (rd_cnt_q != cnt_q);
        default: rd_en = 1'b0;
      endcase
    end
  end

  rx_cfg_ram #(
    .WIDTH  (CFG_WIDTH),
    .ADDR_W (DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_cnt_q[DEPTH_BITS-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      dp_hold_q   <= 1'b0;
      cfg_rst_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      wr_rej_q    <= 1'b0;
`ifdef RX_CFG_CHKSUM_EN
      chksum_q    <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      wr_rej_q    <= wr_en && busy_q;
      cfg_valid_q <= rd_en;
      if (rd_en) rd_cnt_q <= rd_cnt_q + WORD_ONE;
`ifdef RX_CFG_CHKSUM_EN
      if (cfg_valid_q) chksum_q <= chksum_q + rdata;
`endif

      if (busy_q && abort && state_q != ST_ABRST) begin
        state_q   <= ST_ABRST;
        cfg_rst_q <= 1'b1;
        cyc_q     <= RST_LD;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              state_q   <= ST_DRAIN;
              cyc_q     <= DRAIN_LD;
              cnt_q     <= (count > MAX_WORDS) ? MAX_WORDS : count;
              rd_cnt_q  <= '0;
              busy_q    <= 1'b1;
              dp_hold_q <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (cyc_q == '0) begin
              state_q   <= ST_RST;
              cfg_rst_q <= 1'b1;
              cyc_q     <= RST_LD;
`ifdef RX_CFG_CHKSUM_EN
              chksum_q  <= '0;
`endif
            end else begin
              cyc_q <= cyc_q - CYC_ONE;
            end
          end
          ST_RST: begin
            if (cyc_q == '0) begin
              cfg_rst_q <= 1'b0;
              if (cnt_q == '0) begin
                state_q <= ST_SETTLE;
                cyc_q   <= SETTLE_LD;
                done_q  <= SETTLE_IS_ONE;
              end else begin
                state_q <= ST_LOAD;
              end
            end else begin
              cyc_q <= cyc_q - CYC_ONE;
            end
          end
          ST_LOAD: begin
            if (!rd_en) begin
              state_q <= ST_SETTLE;
              cyc_q   <= SETTLE_LD;
              done_q  <= SETTLE_IS_ONE;
            end
          end
          ST_SETTLE: begin
            // done is registered, so it is raised one edge early to land on
            // the final SETTLE cycle.
            if (cyc_q == '0) begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              dp_hold_q <= 1'b0;
            end else begin
              cyc_q  <= cyc_q - CYC_ONE;
              done_q <= (cyc_q == CYC_ONE);
            end
          end
          ST_ABRST: begin
            if (cyc_q == '0) begin
              state_q   <= ST_IDLE;
              cfg_rst_q <= 1'b0;
              busy_q    <= 1'b0;
              dp_hold_q <= 1'b0;
              aborted_q <= 1'b1;
            end else begin
              cyc_q <= cyc_q - CYC_ONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign dp_hold   = dp_hold_q;
  assign cfg_rst   = cfg_rst_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_data  = rdata;
  assign wr_rej    = wr_rej_q;
`ifdef RX_CFG_CHKSUM_EN
  assign cfg_chksum = chksum_q;
`endif

endmodule
